fetch_stage_regs: RTL and testbench
===================================

// Module: fetch_stage_regs
// PURPOSE
// - Downstream end of the hazard-control interface: owns the PC register and the IF/ID pipeline register and obeys
//   PCWrite / IFIDWrite / IFIDFlush from the hazard detection unit.
// - Sits between instruction memory and decode.
// - Applies branch redirects, including a redirect that arrives while the PC is frozen.
// - Keeps saturating stall/flush event counters for debug.
// PARAMETERS
// - WIDTH     32      datapath / address width
// - RESET_PC  32'h0   PC value after reset
// - NOP_INSTR 32'h0   instruction word inserted into IF/ID on flush (sll $0,$0,0)
// - CNT_W     16      width of the stall/flush event counters
// PORTS
// - Clk             in   1      rising-edge clock; the only clock
// - Rst             in   1      synchronous, active-high reset
// - PCWrite         in   1      1 = PC may advance this cycle; 0 = hold PC
// - IFIDWrite       in   1      1 = IF/ID may load; 0 = hold IF/ID
// - IFIDFlush       in   1      1 = load NOP bubble into IF/ID (overrides IFIDWrite)
// - BranchTaken     in   1      branch/jump resolved taken this cycle
// - BranchTarget    in   WIDTH  redirect address, valid with BranchTaken
// - Instruction     in   WIDTH  imem read data for PC_out (combinational read)
// - PC_out          out  WIDTH  current fetch address to imem
// - IFID_Instr      out  WIDTH  registered instruction to decode
// - IFID_PCPlus4    out  WIDTH  registered PC+4 of that instruction
// - IFID_Valid      out  1      0 = IF/ID holds a bubble
// - RedirectPending out  1      1 = a taken branch is latched awaiting PCWrite
// - StallCount      out  CNT_W  cycles with IFIDWrite=0 and IFIDFlush=0 (saturating)
// - FlushCount      out  CNT_W  cycles with IFIDFlush=1 (saturating)
// BEHAVIOUR
// - Clock and reset: one clock (Clk); reset (Rst) is synchronous and active-high. All state updates on posedge Clk.
// - Reset values: PC_out=RESET_PC, IFID_Instr=NOP_INSTR, IFID_PCPlus4=0, IFID_Valid=0, RedirectPending=0,
//   counters=0, FSM=S_BUBBLE.
// - Reset has priority over every other input. Rst asserted mid-stall or mid-redirect drops all pending state.
// - PC next-value priority:
//   1. PCWrite=1 and BranchTaken=1: PC <= BranchTarget; pend <= 0.
//   2. PCWrite=1 and pend=1: PC <= pend_target; pend <= 0.
//   3. PCWrite=1: PC <= PC+4, wrapping modulo 2^WIDTH (no overflow flag).
//   4. PCWrite=0 and BranchTaken=1: PC holds; pend <= 1; pend_target <= BranchTarget (a later branch overwrites an
//      earlier pending one).
//   5. Otherwise PC holds.
//   Redirect latency: target appears on PC_out 1 cycle after the accepting edge.
// - IF/ID priority:
//   1. IFIDFlush=1: Instr <= NOP_INSTR; Valid <= 0; PCPlus4 <= 0. Applies even when IFIDWrite=0.
//   2. IFIDWrite=1: Instr <= Instruction; PCPlus4 <= PC_out+4; Valid <= 1.
//   3. Otherwise hold all fields.
// - Redirect bubble: a fetch that coincides with BranchTaken=1 is wrong-path. If IFIDFlush=0 that cycle, IF/ID
//   still loads a bubble (Valid=0); the block self-squashes.
// - FSM tracks IF/ID content (informational; drives IFID_Valid):
//   - S_BUBBLE --load valid--> S_VALID
//   - S_VALID --stall--> S_HOLD
//   - S_HOLD --IFIDWrite--> S_VALID
//   - any --flush or self-squash--> S_BUBBLE
//   - S_HOLD with flush --> S_BUBBLE (flush wins)
// - Counters: increment by 1 per qualifying cycle, saturate at all-ones, cleared only by Rst. Both conditions are
//   mutually exclusive per cycle.
// - RedirectPending mirrors pend. It is not cleared by IFIDFlush; only by applying the redirect or by Rst.
// - PCWrite=1 with IFIDWrite=0 is legal (PC advances, IF/ID holds); the producer is responsible for consistency.
// STRUCTURE
// - Shared pipeline package:
//   - NOP_INSTR constant
//   - IF/ID state encoding S_BUBBLE / S_VALID / S_HOLD (2-bit)
//   - IF/ID record fields (instr, pcplus4, valid)
// - One natural sub-module: sat_counter (CNT_W, inc, Rst), instantiated twice for StallCount and FlushCount.
// - PC logic and IF/ID logic are separate always blocks; no combinational path from control inputs to PC_out.
// TESTING
// - Rst for 2 cycles, then free run with PCWrite=IFIDWrite=1: PC_out = 0, 4, 8; IFID_Valid=1 from cycle 2;
//   IFID_PCPlus4 = 4, 8.
// - Load-use stall: PCWrite=IFIDWrite=0 for 1 cycle at PC=0x10: PC stays 0x10, IF/ID holds, StallCount=1;
//   PC resumes at 0x14.
// - Branch with PCWrite=1, BranchTaken=1, target 0x40 at PC=0x20: next PC_out=0x40, IFID_Valid=0 for 1 cycle,
//   FlushCount unchanged if IFIDFlush=0.
// - Branch during stall: PCWrite=0, BranchTaken=1, target 0x80; 2 cycles later PCWrite=1:
//   RedirectPending=1 for 2 cycles, then PC_out=0x80 and RedirectPending=0.
// - IFIDFlush=1 with IFIDWrite=0 simultaneously: IFID_Instr=0, Valid=0, FlushCount +1, StallCount unchanged.
// - Saturation and wrap: force PC=0xFFFFFFFC and advance -> PC=0; hold flush 2^CNT_W+3 cycles -> FlushCount=0xFFFF;
//   Rst mid-sequence -> all reset values.

Source files
------------

// File: rtl/fetch_stage_regs_pkg.sv
// Shared fetch/decode pipeline definitions: bubble encoding, IF/ID state
// encoding and the IF/ID record layout.
package fetch_stage_regs_pkg;

   localparam int XLEN = 32;

   // sll $0,$0,0
   localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_BUBBLE = 2'd0,
      S_VALID  = 2'd1,
      S_HOLD   = 2'd2
   } ifid_state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pcplus4;
      logic            valid;
   } ifid_rec_t;

   function automatic logic state_is_valid(input ifid_state_t s);
      return (s == S_VALID) || (s == S_HOLD);
   endfunction

endpackage

// File: rtl/fetch_stage_regs_sat_counter.sv
// Event counter that sticks at all-ones; only reset clears it.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/fetch_stage_regs.sv
// PC register and IF/ID pipeline register under hazard-unit control, with
// deferred branch redirect and stall/flush debug counters.
module fetch_stage_regs
   import fetch_stage_regs_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(DEFAULT_NOP_INSTR),
   parameter int               CNT_W     = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             PCWrite,
   input  logic             IFIDWrite,
   input  logic             IFIDFlush,
   input  logic             BranchTaken,
   input  logic [WIDTH-1:0] BranchTarget,
   input  logic [WIDTH-1:0] Instruction,
   output logic [WIDTH-1:0] PC_out,
   output logic [WIDTH-1:0] IFID_Instr,
   output logic [WIDTH-1:0] IFID_PCPlus4,
   output logic             IFID_Valid,
   output logic             RedirectPending,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   logic [WIDTH-1:0] pc_reg;
   logic             pend_reg;
   logic [WIDTH-1:0] pend_target_reg;
   logic [WIDTH-1:0] instr_reg;
   logic [WIDTH-1:0] pcplus4_reg;
   ifid_state_t      state_reg;
   ifid_state_t      state_next;
   logic             squash;
   logic             bubble_load;

   // A fetch issued in the same cycle as a taken branch is wrong-path.
   assign squash      = IFIDWrite & BranchTaken;
   assign bubble_load = IFIDFlush | squash;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         pc_reg          <= RESET_PC;
         pend_reg        <= 1'b0;
         pend_target_reg <= '0;
      end else if (PCWrite) begin
         pend_reg <= 1'b0;
         if (BranchTaken) begin
            pc_reg <= BranchTarget;
         end else if (pend_reg) begin
            pc_reg <= pend_target_reg;
         end else begin
            pc_reg <= pc_reg + WIDTH'(4);
         end
      end else if (BranchTaken) begin
         // Newest branch wins if several arrive while frozen.
         pend_reg        <= 1'b1;
         pend_target_reg <= BranchTarget;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         instr_reg   <= NOP_INSTR;
         pcplus4_reg <= '0;
      end else if (bubble_load) begin
         instr_reg   <= NOP_INSTR;
         pcplus4_reg <= '0;
      end else if (IFIDWrite) begin
         instr_reg   <= Instruction;
         pcplus4_reg <= pc_reg + WIDTH'(4);
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_reg <= S_BUBBLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (bubble_load) begin
         state_next = S_BUBBLE;
      end else if (IFIDWrite) begin
         state_next = S_VALID;
      end else if (state_reg == S_VALID) begin
         state_next = S_HOLD;
      end
   end

   logic [1:0]       cnt_inc;
   logic [CNT_W-1:0] cnt_val [2];

   // Index 0 counts stalls, index 1 counts flushes; never both in one cycle.
   assign cnt_inc[0] = ~IFIDWrite & ~IFIDFlush;
   assign cnt_inc[1] = IFIDFlush;

   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .Clk   (Clk),
         .Rst   (Rst),
         .inc   (cnt_inc[gi]),
         .count (cnt_val[gi])
      );
   end

   assign PC_out          = pc_reg;
   assign IFID_Instr      = instr_reg;
   assign IFID_PCPlus4    = pcplus4_reg;
   assign IFID_Valid      = state_is_valid(state_reg);
   assign RedirectPending = pend_reg;
   assign StallCount      = cnt_val[0];
   assign FlushCount      = cnt_val[1];

endmodule

// File: tb/tb_fetch_stage_regs.sv
// Directed vector bench for fetch_stage_regs: table of single-cycle steps plus
// hand-written counter-saturation and mid-sequence reset sequences.
module tb_fetch_stage_regs;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        PCWrite, IFIDWrite, IFIDFlush, BranchTaken;
   logic [31:0] BranchTarget;
   logic [31:0] Instruction;
   logic [31:0] PC_out, IFID_Instr, IFID_PCPlus4;
   logic        IFID_Valid, RedirectPending;
   logic [15:0] StallCount, FlushCount;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 Clk = ~Clk;

   // Instruction memory model: word tagged with the low half of its address.
   assign Instruction = {16'hC0DE, PC_out[15:0]};

   fetch_stage_regs #(
      .WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0), .CNT_W(16)
   ) dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .PCWrite         (PCWrite),
      .IFIDWrite       (IFIDWrite),
      .IFIDFlush       (IFIDFlush),
      .BranchTaken     (BranchTaken),
      .BranchTarget    (BranchTarget),
      .Instruction     (Instruction),
      .PC_out          (PC_out),
      .IFID_Instr      (IFID_Instr),
      .IFID_PCPlus4    (IFID_PCPlus4),
      .IFID_Valid      (IFID_Valid),
      .RedirectPending (RedirectPending),
      .StallCount      (StallCount),
      .FlushCount      (FlushCount)
   );

   typedef struct {
      logic        pw, iw, fl, bt;
      logic [31:0] tgt;
      logic [31:0] e_pc, e_instr, e_p4;
      logic        e_valid, e_pend;
      logic [15:0] e_stall, e_flush;
   } vec_t;

   vec_t vecs[23];

   function automatic vec_t mk(input logic pw, iw, fl, bt, input logic [31:0] tgt,
                               input logic [31:0] e_pc, e_instr, e_p4,
                               input logic e_valid, e_pend,
                               input logic [15:0] e_stall, e_flush);
      vec_t v;
      v.pw = pw; v.iw = iw; v.fl = fl; v.bt = bt; v.tgt = tgt;
      v.e_pc = e_pc; v.e_instr = e_instr; v.e_p4 = e_p4;
      v.e_valid = e_valid; v.e_pend = e_pend;
      v.e_stall = e_stall; v.e_flush = e_flush;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic pw, iw, fl, bt, input logic [31:0] tgt);
      PCWrite = pw; IFIDWrite = iw; IFIDFlush = fl; BranchTaken = bt; BranchTarget = tgt;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".pc"},    PC_out, 32'h0);
      chk({tag, ".instr"}, IFID_Instr, 32'h0);
      chk({tag, ".p4"},    IFID_PCPlus4, 32'h0);
      chk({tag, ".valid"}, {31'b0, IFID_Valid}, 32'h0);
      chk({tag, ".pend"},  {31'b0, RedirectPending}, 32'h0);
      chk({tag, ".stall"}, {16'b0, StallCount}, 32'h0);
      chk({tag, ".flush"}, {16'b0, FlushCount}, 32'h0);
   endtask

   initial begin
      //              pw iw fl bt target        pc            instr         pc+4          v  p  stall flush
      vecs[0]  = mk(1, 1, 0, 0, 32'h0,        32'h4,        32'hC0DE0000, 32'h4,        1, 0, 0, 0);
      vecs[1]  = mk(1, 1, 0, 0, 32'h0,        32'h8,        32'hC0DE0004, 32'h8,        1, 0, 0, 0);
      vecs[2]  = mk(1, 1, 0, 0, 32'h0,        32'hC,        32'hC0DE0008, 32'hC,        1, 0, 0, 0);
      vecs[3]  = mk(1, 1, 0, 0, 32'h0,        32'h10,       32'hC0DE000C, 32'h10,       1, 0, 0, 0);
      vecs[4]  = mk(0, 0, 0, 0, 32'h0,        32'h10,       32'hC0DE000C, 32'h10,       1, 0, 1, 0);
      vecs[5]  = mk(1, 1, 0, 0, 32'h0,        32'h14,       32'hC0DE0010, 32'h14,       1, 0, 1, 0);
      vecs[6]  = mk(1, 1, 0, 0, 32'h0,        32'h18,       32'hC0DE0014, 32'h18,       1, 0, 1, 0);
      vecs[7]  = mk(1, 1, 0, 0, 32'h0,        32'h1C,       32'hC0DE0018, 32'h1C,       1, 0, 1, 0);
      vecs[8]  = mk(1, 1, 0, 0, 32'h0,        32'h20,       32'hC0DE001C, 32'h20,       1, 0, 1, 0);
      vecs[9]  = mk(1, 1, 0, 1, 32'h40,       32'h40,       32'h0,        32'h0,        0, 0, 1, 0);
      vecs[10] = mk(1, 1, 0, 0, 32'h0,        32'h44,       32'hC0DE0040, 32'h44,       1, 0, 1, 0);
      vecs[11] = mk(0, 0, 0, 1, 32'h80,       32'h44,       32'hC0DE0040, 32'h44,       1, 1, 2, 0);
      vecs[12] = mk(0, 0, 0, 0, 32'h0,        32'h44,       32'hC0DE0040, 32'h44,       1, 1, 3, 0);
      vecs[13] = mk(1, 1, 0, 0, 32'h0,        32'h80,       32'hC0DE0044, 32'h48,       1, 0, 3, 0);
      vecs[14] = mk(1, 1, 0, 0, 32'h0,        32'h84,       32'hC0DE0080, 32'h84,       1, 0, 3, 0);
      vecs[15] = mk(0, 0, 1, 0, 32'h0,        32'h84,       32'h0,        32'h0,        0, 0, 3, 1);
      vecs[16] = mk(1, 1, 0, 0, 32'h0,        32'h88,       32'hC0DE0084, 32'h88,       1, 0, 3, 1);
      vecs[17] = mk(1, 1, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 0, 3, 1);
      vecs[18] = mk(1, 1, 0, 0, 32'h0,        32'h0,        32'hC0DEFFFC, 32'h0,        1, 0, 3, 1);
      vecs[19] = mk(1, 0, 0, 0, 32'h0,        32'h4,        32'hC0DEFFFC, 32'h0,        1, 0, 4, 1);
      vecs[20] = mk(0, 0, 0, 1, 32'h100,      32'h4,        32'hC0DEFFFC, 32'h0,        1, 1, 5, 1);
      vecs[21] = mk(0, 0, 0, 1, 32'h200,      32'h4,        32'hC0DEFFFC, 32'h0,        1, 1, 6, 1);
      vecs[22] = mk(1, 1, 0, 0, 32'h0,        32'h200,      32'hC0DE0004, 32'h8,        1, 0, 6, 1);

      Rst = 1'b1;
      drive(1, 1, 0, 0, 32'h0);
      tick();
      tick();
      chk_reset_state("reset");
      Rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         drive(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].bt, vecs[i].tgt);
         tick();
         $display("step %0d: pw=%b iw=%b fl=%b bt=%b tgt=%h -> pc=%h instr=%h p4=%h v=%b pend=%b stall=%0d flush=%0d",
                  i, vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].bt, vecs[i].tgt,
                  PC_out, IFID_Instr, IFID_PCPlus4, IFID_Valid, RedirectPending, StallCount, FlushCount);
         chk($sformatf("v%0d.pc", i),    PC_out, vecs[i].e_pc);
         chk($sformatf("v%0d.instr", i), IFID_Instr, vecs[i].e_instr);
         chk($sformatf("v%0d.p4", i),    IFID_PCPlus4, vecs[i].e_p4);
         chk($sformatf("v%0d.valid", i), {31'b0, IFID_Valid}, {31'b0, vecs[i].e_valid});
         chk($sformatf("v%0d.pend", i),  {31'b0, RedirectPending}, {31'b0, vecs[i].e_pend});
         chk($sformatf("v%0d.stall", i), {16'b0, StallCount}, {16'b0, vecs[i].e_stall});
         chk($sformatf("v%0d.flush", i), {16'b0, FlushCount}, {16'b0, vecs[i].e_flush});
      end

      // Flush saturation: count starts at 1, reaches 0xFFFE after 65533 flushes.
      drive(0, 0, 1, 0, 32'h0);
      for (int c = 0; c < 65533; c++) tick();
      $display("flush run 65533 cycles -> flush=%h stall=%0d", FlushCount, StallCount);
      chk("sat.flush_fffe", {16'b0, FlushCount}, 32'h0000FFFE);
      chk("sat.stall_same", {16'b0, StallCount}, 32'h6);
      for (int c = 0; c < 6; c++) tick();
      $display("flush run +6 cycles -> flush=%h", FlushCount);
      chk("sat.flush_ffff", {16'b0, FlushCount}, 32'h0000FFFF);
      chk("sat.pc_held", PC_out, 32'h200);

      // Reset while a redirect is pending drops it.
      drive(0, 0, 0, 1, 32'h300);
      tick();
      $display("pending redirect before reset -> pend=%b", RedirectPending);
      chk("rst.pend_before", {31'b0, RedirectPending}, 32'h1);
      Rst = 1'b1;
      drive(1, 1, 0, 1, 32'h500);
      tick();
      $display("mid-sequence reset -> pc=%h pend=%b flush=%0d", PC_out, RedirectPending, FlushCount);
      chk_reset_state("rst_mid");
      Rst = 1'b0;
      drive(1, 1, 0, 0, 32'h0);
      tick();
      $display("after reset release -> pc=%h instr=%h v=%b", PC_out, IFID_Instr, IFID_Valid);
      chk("rst.pc_after", PC_out, 32'h4);
      chk("rst.instr_after", IFID_Instr, 32'hC0DE0000);
      chk("rst.valid_after", {31'b0, IFID_Valid}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
